// File: rtl/vip_sobel_edge_3x3_8bit.sv
// Sobel 3x3 edge detector: |Gx|+|Gy| over a 3-stage pipeline, thresholded to a 1-bit edge map,
// plus a saturating per-frame edge-pixel counter. Define SOBEL_MAG_OUT_EN to add post_img_mag.
module vip_sobel_edge_3x3_8bit #(
    parameter int unsigned CNT_W      = 20,
    parameter logic [10:0] THRESH_DEF = 11'd128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [7:0]       matrix_p11,
    input  logic [7:0]       matrix_p12,
    input  logic [7:0]       matrix_p13,
    input  logic [7:0]       matrix_p21,
    input  logic [7:0]       matrix_p22,
    input  logic [7:0]       matrix_p23,
    input  logic [7:0]       matrix_p31,
    input  logic [7:0]       matrix_p32,
    input  logic [7:0]       matrix_p33,
    input  logic [10:0]      threshold_i,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic             post_img_bit,
`ifdef SOBEL_MAG_OUT_EN
    output logic [7:0]       post_img_mag,
`endif
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic             edge_cnt_vld_o
);

    function automatic logic [9:0] sum_121(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

`ifdef SOBEL_MAG_OUT_EN
    function automatic logic [7:0] sat_u8(input logic [10:0] v);
        return (v > 11'd255) ? 8'hFF : v[7:0];
    endfunction
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    logic [9:0]       gx_pos_p0, gx_neg_p0, gy_pos_p0, gy_neg_p0;
    logic             vsync_p0, href_p0, vld_p0;
    logic [9:0]       gx_abs_p1, gy_abs_p1;
    logic             vsync_p1, href_p1, vld_p1;
    logic [10:0]      mag_p2;
    logic             is_edge_p2;
    logic             vsync_in_d;
    logic [10:0]      thr_shadow;
    logic             post_vsync_d;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_inc;
    logic             end_of_frame;

    // Stage 1: weighted row/column sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_pos_p0 <= '0;
            gx_neg_p0 <= '0;
            gy_pos_p0 <= '0;
            gy_neg_p0 <= '0;
            vsync_p0  <= 1'b0;
            href_p0   <= 1'b0;
            vld_p0    <= 1'b0;
        end else begin
            gx_pos_p0 <= sum_121(matrix_p13, matrix_p23, matrix_p33);
            gx_neg_p0 <= sum_121(matrix_p11, matrix_p21, matrix_p31);
            gy_pos_p0 <= sum_121(matrix_p11, matrix_p12, matrix_p13);
            gy_neg_p0 <= sum_121(matrix_p31, matrix_p32, matrix_p33);
            vsync_p0  <= per_frame_vsync;
            href_p0   <= per_frame_href;
            vld_p0    <= per_frame_clken;
        end
    end

    // Stage 2: absolute gradients, larger minus smaller so nothing wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_abs_p1 <= '0;
            gy_abs_p1 <= '0;
            vsync_p1  <= 1'b0;
            href_p1   <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            gx_abs_p1 <= abs_diff(gx_pos_p0, gx_neg_p0);
            gy_abs_p1 <= abs_diff(gy_pos_p0, gy_neg_p0);
            vsync_p1  <= vsync_p0;
            href_p1   <= href_p0;
            vld_p1    <= vld_p0;
        end
    end

    // Stage 3: magnitude, threshold, href gating
    assign mag_p2     = {1'b0, gx_abs_p1} + {1'b0, gy_abs_p1};
    assign is_edge_p2 = (mag_p2 > thr_shadow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_bit     <= 1'b0;
`ifdef SOBEL_MAG_OUT_EN
            post_img_mag     <= 8'd0;
`endif
        end else begin
            post_frame_vsync <= vsync_p1;
            post_frame_href  <= href_p1;
            post_frame_clken <= vld_p1;
            post_img_bit     <= href_p1 & is_edge_p2;
`ifdef SOBEL_MAG_OUT_EN
            post_img_mag     <= href_p1 ? sat_u8(mag_p2) : 8'd0;
`endif
        end
    end

    // The threshold only changes on an input-side frame start, so a frame is judged consistently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_in_d <= 1'b0;
            thr_shadow <= THRESH_DEF;
        end else begin
            vsync_in_d <= per_frame_vsync;
            if (per_frame_vsync && !vsync_in_d) begin
                thr_shadow <= threshold_i;
            end
        end
    end

    assign cnt_inc      = post_frame_href & post_frame_clken & post_img_bit;
    assign end_of_frame = post_vsync_d & ~post_frame_vsync;
    assign cnt_next     = sat_inc(run_cnt, cnt_inc);

    // A pixel landing on the end-of-frame cycle is folded into the reported count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vsync_d   <= 1'b0;
            run_cnt        <= '0;
            edge_cnt_o     <= '0;
            edge_cnt_vld_o <= 1'b0;
        end else begin
            post_vsync_d <= post_frame_vsync;
            if (end_of_frame) begin
                edge_cnt_o     <= cnt_next;
                edge_cnt_vld_o <= 1'b1;
                run_cnt        <= '0;
            end else begin
                edge_cnt_vld_o <= 1'b0;
                run_cnt        <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_vip_sobel_edge_3x3_8bit.sv
// Bench for vip_sobel_edge_3x3_8bit: directed frames with literal counts plus randomized frames,
// every output checked each cycle against a behavioural Sobel/threshold/frame-count model.
module tb_vip_sobel_edge_3x3_8bit;

    localparam int          CNT_W      = 4;
    localparam logic [10:0] THRESH_DEF = 11'd128;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;
    localparam int          MAXC       = 16384;

    typedef int win_t [9];

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             per_frame_vsync = 1'b0;
    logic             href = 1'b0;
    logic             clken = 1'b0;
    logic [7:0]       matrix_p11 = '0, matrix_p12 = '0, matrix_p13 = '0;
    logic [7:0]       matrix_p21 = '0, matrix_p22 = '0, matrix_p23 = '0;
    logic [7:0]       matrix_p31 = '0, matrix_p32 = '0, matrix_p33 = '0;
    logic [10:0]      threshold_i = 11'd128;
    logic             post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit;
    logic [CNT_W-1:0] edge_cnt_o;
    logic             edge_cnt_vld_o;
`ifdef SOBEL_MAG_OUT_EN
    logic [7:0]       post_img_mag;
`endif

    always #5 clk = ~clk;

    vip_sobel_edge_3x3_8bit #(.CNT_W(CNT_W), .THRESH_DEF(THRESH_DEF)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(href), .per_frame_clken(clken),
        .matrix_p11(matrix_p11), .matrix_p12(matrix_p12), .matrix_p13(matrix_p13),
        .matrix_p21(matrix_p21), .matrix_p22(matrix_p22), .matrix_p23(matrix_p23),
        .matrix_p31(matrix_p31), .matrix_p32(matrix_p32), .matrix_p33(matrix_p33),
        .threshold_i(threshold_i),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img_bit(post_img_bit),
`ifdef SOBEL_MAG_OUT_EN
        .post_img_mag(post_img_mag),
`endif
        .edge_cnt_o(edge_cnt_o), .edge_cnt_vld_o(edge_cnt_vld_o)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sobel_mag(input win_t p);
        int gx, gy;
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[0] + 2 * p[1] + p[2]) - (p[6] + 2 * p[7] + p[8]);
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    // History of sampled inputs since the last reset release, one entry per clock edge.
    int r_vs [MAXC];
    int r_hr [MAXC];
    int r_ck [MAXC];
    int r_mag [MAXC];
    int r_thr [MAXC];
    int n_edges = 0;

    initial begin : recorder
        win_t w;
        int prev;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                n_edges = 0;
            end else if (n_edges < MAXC) begin
                w[0] = int'(matrix_p11); w[1] = int'(matrix_p12); w[2] = int'(matrix_p13);
                w[3] = int'(matrix_p21); w[4] = int'(matrix_p22); w[5] = int'(matrix_p23);
                w[6] = int'(matrix_p31); w[7] = int'(matrix_p32); w[8] = int'(matrix_p33);
                r_vs[n_edges]  = int'(per_frame_vsync);
                r_hr[n_edges]  = int'(href);
                r_ck[n_edges]  = int'(clken);
                r_mag[n_edges] = sobel_mag(w);
                prev = (n_edges > 0) ? r_vs[n_edges - 1] : 0;
                if (per_frame_vsync && prev == 0) r_thr[n_edges] = int'(threshold_i);
                else r_thr[n_edges] = (n_edges > 0) ? r_thr[n_edges - 1] : int'(THRESH_DEF);
                n_edges++;
            end
        end
    end

    function automatic int vs_at(input int i);  return (i >= 0) ? r_vs[i] : 0;  endfunction
    function automatic int hr_at(input int i);  return (i >= 0) ? r_hr[i] : 0;  endfunction
    function automatic int ck_at(input int i);  return (i >= 0) ? r_ck[i] : 0;  endfunction
    function automatic int mag_at(input int i); return (i >= 0) ? r_mag[i] : 0; endfunction
    function automatic int thr_at(input int i); return (i >= 0) ? r_thr[i] : int'(THRESH_DEF); endfunction

    // Outputs visible after edge e belong to the input taken at edge e-2, judged with the
    // threshold already held when the result is formed.
    function automatic int post_vs(input int e); return vs_at(e - 2); endfunction
    function automatic int post_hr(input int e); return hr_at(e - 2); endfunction
    function automatic int post_ck(input int e); return ck_at(e - 2); endfunction
    function automatic int post_bit(input int e);
        return (hr_at(e - 2) != 0 && mag_at(e - 2) > thr_at(e - 1)) ? 1 : 0;
    endfunction

    initial begin : compare
        int e, c, inc, fall, acc, last_cnt, exp_vld;
        acc = 0;
        last_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                acc = 0;
                last_cnt = 0;
                check("rst_post_vsync", int'(post_frame_vsync), 0);
                check("rst_post_href", int'(post_frame_href), 0);
                check("rst_post_clken", int'(post_frame_clken), 0);
                check("rst_post_img_bit", int'(post_img_bit), 0);
                check("rst_edge_cnt", int'(edge_cnt_o), 0);
                check("rst_edge_cnt_vld", int'(edge_cnt_vld_o), 0);
            end else begin
                e = n_edges - 1;
                c = e - 1;
                inc  = (post_hr(c) != 0 && post_ck(c) != 0 && post_bit(c) != 0) ? 1 : 0;
                fall = (post_vs(c - 1) != 0 && post_vs(c) == 0) ? 1 : 0;
                if (fall != 0) begin
                    last_cnt = (acc + inc > CNT_MAX) ? CNT_MAX : acc + inc;
                    acc = 0;
                    exp_vld = 1;
                end else begin
                    acc = (acc + inc > CNT_MAX) ? CNT_MAX : acc + inc;
                    exp_vld = 0;
                end
                check("post_frame_vsync", int'(post_frame_vsync), post_vs(e));
                check("post_frame_href", int'(post_frame_href), post_hr(e));
                check("post_frame_clken", int'(post_frame_clken), post_ck(e));
                check("post_img_bit", int'(post_img_bit), post_bit(e));
                check("edge_cnt_vld_o", int'(edge_cnt_vld_o), exp_vld);
                check("edge_cnt_o", int'(edge_cnt_o), last_cnt);
`ifdef SOBEL_MAG_OUT_EN
                check("post_img_mag", int'(post_img_mag),
                      post_hr(e) != 0 ? (mag_at(e - 2) > 255 ? 255 : mag_at(e - 2)) : 0);
`endif
            end
        end
    end

    // mode: 0 flat 100, 1 vertical step, 3 small noise near threshold, 4 mag 128, else random
    task automatic set_window(input int mode);
        win_t p;
        int base;
        base = int'($urandom_range(0, 200));
        for (int k = 0; k < 9; k++) begin
            case (mode)
                0:       p[k] = 100;
                1:       p[k] = (k % 3 == 2) ? 255 : 0;
                3:       p[k] = base + int'($urandom_range(0, 20));
                4:       p[k] = (k == 5) ? 64 : 0;
                default: p[k] = int'($urandom_range(0, 255));
            endcase
        end
        matrix_p11 = 8'(p[0]); matrix_p12 = 8'(p[1]); matrix_p13 = 8'(p[2]);
        matrix_p21 = 8'(p[3]); matrix_p22 = 8'(p[4]); matrix_p23 = 8'(p[5]);
        matrix_p31 = 8'(p[6]); matrix_p32 = 8'(p[7]); matrix_p33 = 8'(p[8]);
    endtask

    task automatic end_frame(output int cnt);
        bit got;
        got = 0;
        cnt = -1;
        per_frame_vsync = 1'b0;
        href = 1'b0;
        clken = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (edge_cnt_vld_o) begin
                got = 1;
                cnt = int'(edge_cnt_o);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input int lines, input int width, input int mode, input int thr,
                             input int thr_mid, input bit rand_ck, output int cnt);
        threshold_i = 11'(thr);
        per_frame_vsync = 1'b1;
        href = 1'b0;
        clken = 1'b0;
        set_window(2);
        repeat (2) @(negedge clk);
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < width; x++) begin
                if (l == lines / 2 && x == 0 && thr_mid >= 0) threshold_i = 11'(thr_mid);
                href = 1'b1;
                clken = rand_ck ? ($urandom_range(0, 3) != 0) : 1'b1;
                set_window(mode < 0 ? int'($urandom_range(0, 4)) : mode);
                @(negedge clk);
            end
            href = 1'b0;
            clken = 1'b0;
            set_window(2);
            repeat (2) @(negedge clk);
        end
        end_frame(cnt);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        win_t w;
        int cnt;
        #1 rst_n = 1'b0;

        for (int k = 0; k < 9; k++) w[k] = 100;
        check("model_mag_flat", sobel_mag(w), 0);
        for (int k = 0; k < 9; k++) w[k] = (k % 3 == 2) ? 255 : 0;
        check("model_mag_step", sobel_mag(w), 1020);
        for (int k = 0; k < 9; k++) w[k] = (k == 5) ? 64 : 0;
        check("model_mag_128", sobel_mag(w), 128);

        repeat (3) @(negedge clk);
        check("reset_post_img_bit", int'(post_img_bit), 0);
        check("reset_edge_cnt", int'(edge_cnt_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single step pixel: output must appear exactly three clocks later
        threshold_i = 11'd128;
        per_frame_vsync = 1'b1;
        set_window(0);
        repeat (3) @(negedge clk);
        href = 1'b1; clken = 1'b1; set_window(1);
        @(negedge clk);
        href = 1'b0; clken = 1'b0; set_window(0);
        @(negedge clk);
        check("latency_clk2", int'(post_img_bit), 0);
        @(negedge clk);
        check("latency_clk3", int'(post_img_bit), 1);
`ifdef SOBEL_MAG_OUT_EN
        check("latency_mag_sat", int'(post_img_mag), 255);
`endif
        @(negedge clk);
        check("latency_clk4", int'(post_img_bit), 0);
        end_frame(cnt);
        check("count_single", cnt, 1);

        run_frame(3, 8, 0, 0, -1, 1'b0, cnt);
        check("count_flat_thr0", cnt, 0);
        run_frame(2, 6, 1, 128, -1, 1'b0, cnt);
        check("count_step", cnt, 12);
        run_frame(2, 5, 4, 128, -1, 1'b0, cnt);
        check("count_mag128_thr128", cnt, 0);
        run_frame(2, 5, 4, 127, -1, 1'b0, cnt);
        check("count_mag128_thr127", cnt, 10);
        run_frame(4, 3, 1, 128, 2000, 1'b0, cnt);
        check("count_thr_change_midframe", cnt, 12);
        run_frame(4, 3, 1, 2000, -1, 1'b0, cnt);
        check("count_thr2000_next_frame", cnt, 0);
        run_frame(10, 16, 1, 128, -1, 1'b0, cnt);
        check("count_saturated", cnt, 15);
        run_frame(1, 5, 1, 128, -1, 1'b0, cnt);
        check("count_after_saturation", cnt, 5);

        // reset in the middle of a frame full of edges
        threshold_i = 11'd128;
        per_frame_vsync = 1'b1;
        set_window(2);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            href = 1'b1; clken = 1'b1; set_window(1);
            @(negedge clk);
        end
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        href = 1'b0;
        clken = 1'b0;
        #1;
        check("async_rst_post_img_bit", int'(post_img_bit), 0);
        check("async_rst_post_vsync", int'(post_frame_vsync), 0);
        check("async_rst_post_href", int'(post_frame_href), 0);
        check("async_rst_edge_cnt", int'(edge_cnt_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            href = 1'b1; clken = 1'b1; set_window(1);
            @(negedge clk);
        end
        href = 1'b0; clken = 1'b0; set_window(2);
        repeat (2) @(negedge clk);
        end_frame(cnt);
        check("count_after_reset", cnt, 6);

        for (int f = 0; f < 24; f++) begin
            run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 12)), -1,
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2040))
                                                  : int'($urandom_range(60, 200)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2040)) : -1,
                      1'b1, cnt);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
